// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target register file
package i2c_pkg;

    localparam int   BYTE_W   = 8;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronisers, edge history and START/STOP detection
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   scl_i       raw SCL pin level
//   sda_i       raw SDA pin level
//   scl_rise    one-clk pulse on synchronised SCL rising edge
//   scl_fall    one-clk pulse on synchronised SCL falling edge
//   sda_s       synchronised SDA level
//   start_det   one-clk pulse: SDA fell while SCL high
//   stop_det    one-clk pulse: SDA rose while SCL high
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Idle bus level is high, so the chain resets to 1 to avoid a false event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high in both samples so an SCL edge never looks like START/STOP.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with pointer-addressed byte register file
//
// Ports:
//   clk, rst     system clock (>= 10x SCL), asynchronous active-high reset
//   en           target enable; 0 = NACK every address
//   scl_i, sda_i raw pin levels
//   sda_oe       1 = pull SDA low (open drain)
//   busy         high from address-matched START until STOP
//   update       one-clk pulse after a written byte is stored
//   upd_addr     register index written, valid with update
//   host_raddr   on-chip read index
//   host_rdata   combinational read of register at host_raddr
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR    = 7'h42,
    parameter int         REG_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1,
    localparam int        PW          = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic          update,
    output logic [PW-1:0] upd_addr,
    input  logic [PW-1:0] host_raddr,
    output logic [7:0]    host_rdata
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [7:0]    sr, sr_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          rw, rw_nxt;
    logic          busy_nxt;
    logic          sda_oe_nxt;
    logic          mem_we;
    logic [7:0]    mem [REG_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(REG_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    logic [7:0]    byte_in;
    logic          byte_end;
    logic          ack_end;
    logic          addr_hit;
    logic [PW-1:0] adv_ptr;

    assign byte_in  = {sr[6:0], sda_s};
    assign byte_end = scl_rise && (cnt == 4'(BYTE_W - 1));
    // Ack states use cnt as a phase flag: 0 = still in the last data bit, 1 = in the ack bit.
    assign ack_end  = scl_fall && (cnt == 4'd1);
    assign addr_hit = (byte_in[7:1] == TGT_ADDR) && en;
    assign adv_ptr  = AUTO_INC ? ptr_inc(ptr) : ptr;

    assign host_rdata = mem[host_raddr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            update   <= 1'b0;
            upd_addr <= '0;
            for (int i = 0; i < REG_DEPTH; i++) mem[i] <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sr     <= sr_nxt;
            ptr    <= ptr_nxt;
            rw     <= rw_nxt;
            busy   <= busy_nxt;
            sda_oe <= sda_oe_nxt;
            update <= mem_we;
            if (mem_we) begin
                mem[ptr] <= byte_in;
                upd_addr <= ptr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:     if (byte_end) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (ack_end)  state_nxt = rw ? RD_DATA : PTR;
                PTR:      if (byte_end) state_nxt = PTR_ACK;
                PTR_ACK:  if (ack_end)  state_nxt = WR_DATA;
                WR_DATA:  if (byte_end) state_nxt = WR_ACK;
                WR_ACK:   if (ack_end)  state_nxt = WR_DATA;
                RD_DATA:  if (byte_end) state_nxt = RD_ACK;
                RD_ACK:   if (scl_rise && cnt == 4'd1)
                              state_nxt = (sda_s == I2C_ACK) ? RD_DATA : WAIT_STOP;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        cnt_nxt    = cnt;
        sr_nxt     = sr;
        ptr_nxt    = ptr;
        rw_nxt     = rw;
        busy_nxt   = busy;
        sda_oe_nxt = sda_oe;
        mem_we     = 1'b0;
        if (stop_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start_det) begin
            cnt_nxt    = '0;
            sda_oe_nxt = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise) begin
                        sr_nxt  = byte_in;
                        cnt_nxt = byte_end ? 4'd0 : cnt + 4'd1;
                        if (byte_end) begin
                            if (state == ADDR && addr_hit) begin
                                busy_nxt = 1'b1;
                                rw_nxt   = byte_in[0];
                            end
                            if (state == PTR)     ptr_nxt = byte_in[PW-1:0];
                            if (state == WR_DATA) mem_we  = 1'b1;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: begin
                    if (scl_fall && cnt == 4'd0) begin
                        sda_oe_nxt = ~I2C_ACK;
                        cnt_nxt    = 4'd1;
                    end else if (ack_end) begin
                        cnt_nxt    = '0;
                        sda_oe_nxt = 1'b0;
                        // A read starts driving its MSB on the same fall that ends the address ACK.
                        if (state == ADDR_ACK && rw) begin
                            sr_nxt     = mem[ptr];
                            sda_oe_nxt = ~mem[ptr][7];
                        end
                        if (state == WR_ACK) ptr_nxt = adv_ptr;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) sda_oe_nxt = ~sr[7];
                    if (scl_rise) begin
                        sr_nxt  = {sr[6:0], 1'b0};
                        cnt_nxt = byte_end ? 4'd0 : cnt + 4'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_fall && cnt == 4'd0) begin
                        sda_oe_nxt = 1'b0;
                        cnt_nxt    = 4'd1;
                    end else if (scl_rise && cnt == 4'd1) begin
                        cnt_nxt = '0;
                        if (sda_s == I2C_ACK) begin
                            ptr_nxt = adv_ptr;
                            sr_nxt  = mem[adv_ptr];
                        end
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

endmodule
